// File: rtl/par_sink_to_counters_pkg.sv
// Shared packet-layout definitions and helpers for the NoC traffic sink.
//
// The `ADDR_BITS / `PAYLOAD_SIZE / `NUM_NODES macros are the node-wide
// packet layout that the traffic sources already use. The field-select
// macros let both ends pick the same bits out of a packet word.
// Packet word layout: {source id, dest addr}, with dest in the low bits.

`ifndef PAR_SINK_TO_COUNTERS_DEFINES
`define PAR_SINK_TO_COUNTERS_DEFINES
`define ADDR_BITS     3
`define PAYLOAD_SIZE  4
`define NUM_NODES     6
`define PKT_DEST_LSB  0
`define PKT_DEST_MSB  (`ADDR_BITS-1)
`define PKT_SRC_LSB   (`ADDR_BITS)
`define PKT_SRC_MSB   (`ADDR_BITS+`PAYLOAD_SIZE-1)
`endif

package par_sink_to_counters_pkg;

  localparam int PKT_W     = `PAYLOAD_SIZE + `ADDR_BITS;
  localparam int NUM_NODES = `NUM_NODES;

  // A packet counts as delivered only if it is addressed to this node and
  // carries a source id that names a real node.
  function automatic logic delivered_ok(input logic [`ADDR_BITS-1:0]    dest,
                                        input logic [`PAYLOAD_SIZE-1:0] src,
                                        input int                       node_id);
    return (int'(dest) == node_id) && (int'(src) < NUM_NODES);
  endfunction

endpackage

// File: rtl/par_sink_to_counters_if.sv
// Valid/busy packet handshake between a NoC router port and a sink.
//   item_in : packet word {source id, dest addr}
//   valid   : one-cycle pulse per packet
//   busy    : backpressure from the receiver
// master = sender side, slave = receiver side.

interface par_sink_to_counters_if;
  import par_sink_to_counters_pkg::*;

  logic [PKT_W-1:0] item_in;
  logic             valid;
  logic             busy;

  modport master (output item_in, output valid, input  busy);
  modport slave  (input  item_in, input  valid, output busy);

endinterface

// File: rtl/par_sink_to_counters_sink_fifo.sv
// sink_fifo: small circular packet buffer for the traffic sink.
//   clk, reset : clock, asynchronous active-high reset
//   push, pop  : write din / retire the head entry (caller guards full/empty)
//   din, dout  : write data / head-of-queue data (combinational read)
//   occupancy  : stored entries, 0..depth
//   full, empty: derived from occupancy
// Pointers wrap naturally; the separate occupancy count tells full from
// empty. A same-edge push and pop cannot hit one slot: the head is read
// combinationally before the edge that overwrites anything.

module sink_fifo #(
  parameter  int depth = 4,
  parameter  int width = 8,
  localparam int ptr_w = $clog2(depth),
  localparam int occ_w = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic [occ_w-1:0] occupancy,
  output logic             full,
  output logic             empty
);

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [occ_w-1:0] occ_q, occ_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + ptr_w'(push);
    rd_ptr_d = rd_ptr_q + ptr_w'(pop);
    occ_d    = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + occ_w'(1);
      2'b01:   occ_d = occ_q - occ_w'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // NOTE: storage has no reset; the occupancy count alone says which entries
  // are live, so clearing the array would only cost flops.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= din;
  end

  assign dout      = mem[rd_ptr_q];
  assign occupancy = occ_q;
  assign full      = (occ_q == occ_w'(depth));
  assign empty     = (occ_q == '0);

endmodule

// File: rtl/par_sink_to_counters.sv
// par_sink_to_counters: destination-end traffic sink for the NoC.
// Accepts packets on a valid/busy handshake, buffers them in sink_fifo and
// drains them at a programmable rate, checking each one for correct delivery.
//   clk, reset     : clock, asynchronous active-high reset
//   up             : packet handshake (item_in, valid in; busy out)
//   drain_en       : consumer ready, permits pops
//   stat_sel       : source index for stat_count
//   stat_count     : packets received from source stat_sel (combinational)
//   total_count    : correctly delivered packets
//   misroute_count : popped packets with wrong dest or invalid source
//   drop_count     : packets that arrived while the FIFO was full
//   err            : sticky, set on any misroute or drop
// Statistic counters saturate at all-ones.

module par_sink_to_counters
  import par_sink_to_counters_pkg::*;
#(
  parameter int id           = -1,
  parameter int depth        = 4,
  parameter int drain_period = 1,
  parameter int cnt_w        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  par_sink_to_counters_if.slave up,
  input  logic                  drain_en,
  input  logic [`ADDR_BITS-1:0] stat_sel,
  output logic [cnt_w-1:0]      stat_count,
  output logic [cnt_w-1:0]      total_count,
  output logic [cnt_w-1:0]      misroute_count,
  output logic [cnt_w-1:0]      drop_count,
  output logic                  err
);

  localparam int occ_w = $clog2(depth + 1);
  localparam int per_w = (drain_period > 1) ? $clog2(drain_period) : 1;
  localparam int idx_w = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

  function automatic logic [cnt_w-1:0] sat_inc(input logic [cnt_w-1:0] v);
    return (&v) ? v : v + cnt_w'(1);
  endfunction

  logic [occ_w-1:0]         occupancy;
  logic                     full, empty;
  logic [PKT_W-1:0]         head;
  logic [`ADDR_BITS-1:0]    head_dest;
  logic [`PAYLOAD_SIZE-1:0] head_src;
  logic [idx_w-1:0]         head_idx;
  logic                     head_ok;
  logic                     accept, drop, pop;

  logic [per_w-1:0] period_q, period_d;
  logic [cnt_w-1:0] rx_q [NUM_NODES];
  logic [cnt_w-1:0] rx_d [NUM_NODES];
  logic [cnt_w-1:0] total_q, total_d;
  logic [cnt_w-1:0] misroute_q, misroute_d;
  logic [cnt_w-1:0] drop_q, drop_d;
  logic             err_q, err_d;

  // Acceptance looks only at pre-edge occupancy; a pop in the same cycle
  // does not make room for the arriving packet.
  assign accept = up.valid & ~full;
  assign drop   = up.valid & full;
  assign pop    = drain_en & ~empty & (period_q == '0);

  // One slot of slack absorbs a packet launched in the cycle busy rises.
  assign up.busy = (occupancy >= occ_w'(depth - 1));

  sink_fifo #(
    .depth (depth),
    .width (PKT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .pop       (pop),
    .din       (up.item_in),
    .dout      (head),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty)
  );

  assign head_dest = head[`PKT_DEST_MSB:`PKT_DEST_LSB];
  assign head_src  = head[`PKT_SRC_MSB:`PKT_SRC_LSB];
  assign head_idx  = idx_w'(head_src);
  assign head_ok   = delivered_ok(head_dest, head_src, id);

  // NOTE: combinational blocks use blocking assignments and give every
  // target a default first, so no path leaves a value unassigned (no latch).
  always_comb begin
    period_d   = period_q;
    rx_d       = rx_q;
    total_d    = total_q;
    misroute_d = misroute_q;
    drop_d     = drop_q;
    err_d      = err_q;

    // The drain timer runs whenever drain_en is high, popping or not.
    if (drain_en) begin
      period_d = (period_q == per_w'(drain_period - 1)) ? '0 : period_q + per_w'(1);
    end

    if (drop) begin
      drop_d = sat_inc(drop_q);
      err_d  = 1'b1;
    end

    if (pop) begin
      if (head_ok) begin
        rx_d[head_idx] = sat_inc(rx_q[head_idx]);
        total_d        = sat_inc(total_q);
      end else begin
        misroute_d = sat_inc(misroute_q);
        err_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q   <= '0;
      total_q    <= '0;
      misroute_q <= '0;
      drop_q     <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < NUM_NODES; i++) rx_q[i] <= '0;
    end else begin
      period_q   <= period_d;
      total_q    <= total_d;
      misroute_q <= misroute_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
      rx_q       <= rx_d;
    end
  end

  assign stat_count     = (int'(stat_sel) < NUM_NODES) ? rx_q[idx_w'(stat_sel)] : '0;
  assign total_count    = total_q;
  assign misroute_count = misroute_q;
  assign drop_count     = drop_q;
  assign err            = err_q;

endmodule

// File: tb/tb_par_sink_to_counters.sv
// Directed bench for par_sink_to_counters. dut_a: id=3, depth=4,
// drain_period=1, 16-bit counters. dut_b: id=3, depth=4, drain_period=3,
// 2-bit counters so saturation is reachable in a few packets.

module tb_par_sink_to_counters;
  import par_sink_to_counters_pkg::*;

  localparam int ID = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  par_sink_to_counters_if bus_a ();
  par_sink_to_counters_if bus_b ();

  logic                  drain_a, drain_b;
  logic [`ADDR_BITS-1:0] sel_a, sel_b;
  logic [15:0]           stat_a, total_a, mis_a, drop_a;
  logic [1:0]            stat_b, total_b, mis_b, drop_b;
  logic                  err_a, err_b;

  int n_checks = 0;
  int n_bad    = 0;

  par_sink_to_counters #(.id(ID), .depth(4), .drain_period(1), .cnt_w(16)) dut_a (
    .clk            (clk),
    .reset          (reset),
    .up             (bus_a),
    .drain_en       (drain_a),
    .stat_sel       (sel_a),
    .stat_count     (stat_a),
    .total_count    (total_a),
    .misroute_count (mis_a),
    .drop_count     (drop_a),
    .err            (err_a)
  );

  par_sink_to_counters #(.id(ID), .depth(4), .drain_period(3), .cnt_w(2)) dut_b (
    .clk            (clk),
    .reset          (reset),
    .up             (bus_b),
    .drain_en       (drain_b),
    .stat_sel       (sel_b),
    .stat_count     (stat_b),
    .total_count    (total_b),
    .misroute_count (mis_b),
    .drop_count     (drop_b),
    .err            (err_b)
  );

  // Receive log for the primary sink.
  always @(posedge clk) begin
    if (!reset && dut_a.pop && dut_a.head_ok)
      $display("##,rx,%0d,%0d", ID, dut_a.head_src);
  end

  function automatic logic [PKT_W-1:0] pkt(input int src, input int dest);
    return {`PAYLOAD_SIZE'(src), `ADDR_BITS'(dest)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus_a.valid   = 1'b0;
    bus_a.item_in = '0;
    bus_b.valid   = 1'b0;
    bus_b.item_in = '0;
    drain_a       = 1'b0;
    drain_b       = 1'b0;
    sel_a         = '0;
    sel_b         = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    sel_a = 3'd1;
    #1;
    n_checks++; if (total_a !== 16'd0) begin n_bad++; $display("FAIL reset_total got=%0d want=0", total_a); end
    n_checks++; if (mis_a !== 16'd0) begin n_bad++; $display("FAIL reset_misroute got=%0d want=0", mis_a); end
    n_checks++; if (drop_a !== 16'd0) begin n_bad++; $display("FAIL reset_drop got=%0d want=0", drop_a); end
    n_checks++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%0b want=0", err_a); end
    n_checks++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%0b want=0", bus_a.busy); end
    n_checks++; if (stat_a !== 16'd0) begin n_bad++; $display("FAIL reset_stat got=%0d want=0", stat_a); end
  endtask

  task automatic test_basic();
    int exp_total [3] = '{0, 1, 2};
    do_reset();
    drain_a       = 1'b1;
    sel_a         = 3'd1;
    bus_a.item_in = pkt(1, ID);
    bus_a.valid   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (total_a !== 16'(exp_total[i])) begin
        n_bad++; $display("FAIL basic_latency edge=%0d got=%0d want=%0d", i, total_a, exp_total[i]);
      end
    end
    bus_a.valid = 1'b0;
    tick();
    tick();
    n_checks++; if (total_a !== 16'd3) begin n_bad++; $display("FAIL basic_total got=%0d want=3", total_a); end
    n_checks++; if (stat_a !== 16'd3) begin n_bad++; $display("FAIL basic_stat1 got=%0d want=3", stat_a); end
    n_checks++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL basic_err got=%0b want=0", err_a); end
  endtask

  task automatic test_backpressure();
    logic exp_busy [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int   exp_drop [5] = '{0, 0, 0, 0, 1};
    do_reset();
    bus_a.item_in = pkt(1, ID);
    bus_a.valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (bus_a.busy !== exp_busy[i]) begin
        n_bad++; $display("FAIL bp_busy edge=%0d got=%0b want=%0b", i, bus_a.busy, exp_busy[i]);
      end
      n_checks++;
      if (drop_a !== 16'(exp_drop[i])) begin
        n_bad++; $display("FAIL bp_drop edge=%0d got=%0d want=%0d", i, drop_a, exp_drop[i]);
      end
    end
    bus_a.valid = 1'b0;
    n_checks++; if (err_a !== 1'b1) begin n_bad++; $display("FAIL bp_err got=%0b want=1", err_a); end
    drain_a = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (total_a !== 16'd4) begin n_bad++; $display("FAIL bp_total got=%0d want=4", total_a); end
    n_checks++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL bp_busy_drained got=%0b want=0", bus_a.busy); end
    n_checks++; if (err_a !== 1'b1) begin n_bad++; $display("FAIL bp_err_sticky got=%0b want=1", err_a); end
  endtask

  task automatic test_misroute();
    do_reset();
    drain_a       = 1'b1;
    sel_a         = 3'd2;
    bus_a.item_in = pkt(2, 5);
    bus_a.valid   = 1'b1;
    tick();
    bus_a.valid = 1'b0;
    tick();
    n_checks++; if (mis_a !== 16'd1) begin n_bad++; $display("FAIL mis_dest_count got=%0d want=1", mis_a); end
    n_checks++; if (err_a !== 1'b1) begin n_bad++; $display("FAIL mis_err got=%0b want=1", err_a); end
    n_checks++; if (stat_a !== 16'd0) begin n_bad++; $display("FAIL mis_stat2 got=%0d want=0", stat_a); end
    n_checks++; if (total_a !== 16'd0) begin n_bad++; $display("FAIL mis_total got=%0d want=0", total_a); end
    // Source id beyond the node count is also a misroute.
    bus_a.item_in = pkt(7, ID);
    bus_a.valid   = 1'b1;
    tick();
    bus_a.valid = 1'b0;
    tick();
    sel_a = 3'd7;
    #1;
    n_checks++; if (mis_a !== 16'd2) begin n_bad++; $display("FAIL mis_src_count got=%0d want=2", mis_a); end
    n_checks++; if (total_a !== 16'd0) begin n_bad++; $display("FAIL mis_src_total got=%0d want=0", total_a); end
    n_checks++; if (stat_a !== 16'd0) begin n_bad++; $display("FAIL mis_stat7 got=%0d want=0", stat_a); end
  endtask

  task automatic test_drain_period();
    int exp_total [7] = '{1, 1, 1, 2, 2, 2, 3};
    do_reset();
    bus_b.item_in = pkt(0, ID);
    bus_b.valid   = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus_b.valid = 1'b0;
    n_checks++; if (bus_b.busy !== 1'b1) begin n_bad++; $display("FAIL period_preload_busy got=%0b want=1", bus_b.busy); end
    n_checks++; if (total_b !== 2'd0) begin n_bad++; $display("FAIL period_preload_total got=%0d want=0", total_b); end
    drain_b = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++;
      if (total_b !== 2'(exp_total[i])) begin
        n_bad++; $display("FAIL period_total edge=%0d got=%0d want=%0d", i, total_b, exp_total[i]);
      end
    end
  endtask

  // Runs straight after test_drain_period: dut_b counters already at 3 (all-ones).
  task automatic test_saturation();
    sel_b = 3'd0;
    for (int p = 0; p < 2; p++) begin
      bus_b.item_in = pkt(0, ID);
      bus_b.valid   = 1'b1;
      tick();
      bus_b.valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
    end
    n_checks++; if (total_b !== 2'd3) begin n_bad++; $display("FAIL sat_total got=%0d want=3", total_b); end
    n_checks++; if (stat_b !== 2'd3) begin n_bad++; $display("FAIL sat_stat0 got=%0d want=3", stat_b); end
    n_checks++; if (err_b !== 1'b0) begin n_bad++; $display("FAIL sat_err got=%0b want=0", err_b); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus_a.item_in = pkt(1, ID);
    bus_a.valid   = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_checks++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_pre got=%0b want=1", bus_a.busy); end
    // Occupancy depth-1: push and pop in the same cycle.
    drain_a       = 1'b1;
    bus_a.item_in = pkt(4, ID);
    tick();
    bus_a.valid = 1'b0;
    n_checks++; if (bus_a.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_same got=%0b want=1", bus_a.busy); end
    n_checks++; if (drop_a !== 16'd0) begin n_bad++; $display("FAIL b2b_drop got=%0d want=0", drop_a); end
    n_checks++; if (total_a !== 16'd1) begin n_bad++; $display("FAIL b2b_total_first got=%0d want=1", total_a); end
    for (int i = 0; i < 4; i++) tick();
    sel_a = 3'd4;
    #1;
    n_checks++; if (total_a !== 16'd4) begin n_bad++; $display("FAIL b2b_total got=%0d want=4", total_a); end
    n_checks++; if (stat_a !== 16'd1) begin n_bad++; $display("FAIL b2b_stat4 got=%0d want=1", stat_a); end
    sel_a = 3'd1;
    #1;
    n_checks++; if (stat_a !== 16'd3) begin n_bad++; $display("FAIL b2b_stat1 got=%0d want=3", stat_a); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drain_a       = 1'b1;
    sel_a         = 3'd1;
    bus_a.item_in = pkt(1, ID);
    bus_a.valid   = 1'b1;
    tick();
    bus_a.item_in = pkt(2, 5);
    tick();
    bus_a.valid = 1'b0;
    tick();
    n_checks++; if (total_a !== 16'd1 || mis_a !== 16'd1) begin
      n_bad++; $display("FAIL rmid_pre total=%0d mis=%0d want=1,1", total_a, mis_a);
    end
    drain_a       = 1'b0;
    bus_a.item_in = pkt(1, ID);
    bus_a.valid   = 1'b1;
    tick();
    tick();
    bus_a.valid = 1'b0;
    // Asynchronous reset between edges.
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (total_a !== 16'd0) begin n_bad++; $display("FAIL rmid_total got=%0d want=0", total_a); end
    n_checks++; if (mis_a !== 16'd0) begin n_bad++; $display("FAIL rmid_misroute got=%0d want=0", mis_a); end
    n_checks++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL rmid_err got=%0b want=0", err_a); end
    n_checks++; if (stat_a !== 16'd0) begin n_bad++; $display("FAIL rmid_stat got=%0d want=0", stat_a); end
    tick();
    reset = 1'b0;
    tick();
    drain_a     = 1'b1;
    bus_a.valid = 1'b1;
    tick();
    bus_a.valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_checks++; if (total_a !== 16'd1) begin n_bad++; $display("FAIL rmid_after_total got=%0d want=1", total_a); end
    n_checks++; if (stat_a !== 16'd1) begin n_bad++; $display("FAIL rmid_after_stat got=%0d want=1", stat_a); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_misroute();
    test_drain_period();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/par_sink_to_counters.md
Name: par_sink_to_counters

Overview:
- Destination-end traffic sink for the NoC: terminates packets from the local router port, i.e. the receiving end of the node traffic sources.
- Packet format: {payload = source id, dest addr}. Accepts packets under a valid/busy handshake, buffers them in a small FIFO and drains at a programmable rate.
- Each drained packet is checked for correct delivery; per-source receive counts, a total, misroute/drop counts and a sticky error are maintained for the bench.

Parameters:
- id, -1, this node's address; -1 disables the rx log line.
- depth, 4, FIFO entries; power of two, >= 2.
- drain_period, 1, cycles between pops while drain_en is high; 1 means every cycle.
- cnt_w, 16, width of every statistic counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- item_in  in  `PAYLOAD_SIZE+`ADDR_BITS  packet: [`ADDR_BITS-1:0] = dest; upper field = source id.
- valid  in  1  item_in is valid this cycle; single-cycle pulse per packet.
- busy  out  1  backpressure to the upstream sender.
- drain_en  in  1  consumer ready; permits pops.
- stat_sel  in  `ADDR_BITS  source index for stat_count.
- stat_count  out  cnt_w  packets received from source stat_sel; combinational read.
- total_count  out  cnt_w  correctly delivered packets.
- misroute_count  out  cnt_w  popped packets with dest != id or source >= `NUM_NODES.
- drop_count  out  cnt_w  packets arriving while FIFO full.
- err  out  1  sticky; set on any misroute or drop.

Behaviour:
- Reset (async): FIFO empty, pointers 0, all counters 0, per-source array cleared, err=0, drain-period counter 0, busy=0.
- busy is driven from registered occupancy: busy = (occupancy >= depth-1). The one slot of slack absorbs a packet launched in the cycle busy rises.
- Accept: on posedge, if valid and occupancy < depth, item_in is written at the write pointer. Acceptance uses the pre-edge occupancy; a same-cycle pop does not create room.
- Drop: valid while occupancy == depth -> item discarded, drop_count+1, err<=1.
- Pop eligibility: drain_en & !empty & (period counter == 0).
  - Period counter: increments while drain_en is high and wraps at drain_period-1. Holds while drain_en is low. drain_period=1 means eligible every cycle.
- Pop action, at the same edge:
  - dest == id and src < `NUM_NODES: rx[src]+1 and total_count+1. If id != -1, print "##,rx,<id>,<src>".
  - Otherwise: misroute_count+1, err<=1. The per-source array is untouched.
- Latency: packet accepted at edge k is popped no earlier than edge k+1; its counter updates are visible after edge k+1.
- Simultaneous push and pop: both occur and occupancy is unchanged. Push and pop on the same slot are impossible, because the read precedes the overwrite.
- Pointers are log2(depth) bits, with natural wrap. A separate occupancy counter 0..depth distinguishes full from empty.
- All counters saturate at all-ones and do not wrap.
- err clears only on reset.
- valid pulses back-to-back are legal; each one is a separate packet.
- Reset mid-operation discards FIFO contents and all statistics.

Decomposition:
- Shared defines header, already used by the source side: `PAYLOAD_SIZE, `ADDR_BITS, `NUM_NODES.
  - Add field-select macros `PKT_DEST_LSB/MSB and `PKT_SRC_LSB/MSB so source and sink agree on the packet layout.
- Sub-module: sink_fifo (depth, width parameters). Ports: push, pop, din, dout, occupancy; full/empty derived.
  - The top level holds the handshake, drain timer, checking and statistics.

Test Plan:
- id=3; send three packets {src=1, dest=3} with drain_en=1 -> total_count=3; stat_count(sel=1)=3; err=0; three "##,rx,3,1" lines.
- id=3, drain_en=0, depth=4; send 5 packets one per cycle -> busy rises after the 3rd accept; 4 stored; 5th dropped; drop_count=1; err=1. Then set drain_en=1 -> total_count=4.
- id=3; send {src=2, dest=5} -> misroute_count=1; err=1; stat_count(sel=2)=0; total_count=0.
- drain_period=3, FIFO preloaded with 3 valid packets, drain_en held high -> pops at cycles 0, 3, 6 relative to drain_en rise.
- FIFO at occupancy depth-1; valid and pop in the same cycle -> packet accepted, occupancy unchanged, no drop.
- Assert reset with 2 packets queued and counters nonzero -> all outputs 0 immediately; the next packet counts from 1.
